// File: rtl/serial_2_parallel.sv
`default_nettype none
// ============================================================================
//  Module      : serial_2_parallel
//  Description : Collects 2*N one-bit serial lanes (N real, N imaginary),
//                W bits each, MSB first, and presents N signed W-bit complex
//                samples in parallel under a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_2_parallel #(
  parameter int N = 32,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable_i,
  input  logic           frame_start_i,
  input  logic [N-1:0]   real_in_i,     // bit i = lane i
  input  logic [N-1:0]   imag_in_i,
  output logic [N*W-1:0] real_out_o,    // lane i at [i*W +: W], signed
  output logic [N*W-1:0] imag_out_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           busy_o,
  output logic           overflow_o
);

  localparam int            CW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N*W-1:0]  real_sr_q, imag_sr_q;
  logic [N*W-1:0]  real_out_q, imag_out_q;
  logic            out_valid_q, overflow_q;

  logic [N*W-1:0]  w_real_nx, w_imag_nx;
  logic            w_take, w_complete, w_load;
  logic [CW-1:0]   w_pos;

  // A bit is taken when enabled and either a frame is open or one starts now.
  assign w_take     = enable_i && (frame_start_i || (state_q == S_SHIFT));
  // frame_start always restarts at the MSB, discarding any partial frame.
  assign w_pos      = frame_start_i ? '0 : cnt_q;
  assign w_complete = w_take && (w_pos == C_LAST);
  // The holding register may be refilled if empty or drained on this edge.
  assign w_load     = w_complete && (!out_valid_q || out_ready_i);

  // Per-lane next shift value; stale bits of an aborted frame shift out
  // naturally because a complete frame always shifts in exactly W bits.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_real_nx[i*W +: W] = (real_sr_q[i*W +: W] << 1) | W'(real_in_i[i]);
    assign w_imag_nx[i*W +: W] = (imag_sr_q[i*W +: W] << 1) | W'(imag_in_i[i]);
  end

  // State and bit counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: advance on each taken bit, return to idle on completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_take) begin
      if (w_complete) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_SHIFT;
        cnt_d   = w_pos + CW'(1);
      end
    end
  end

  // Lane shift registers advance only on taken bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      real_sr_q <= '0;
      imag_sr_q <= '0;
    end else if (w_take) begin
      real_sr_q <= w_real_nx;
      imag_sr_q <= w_imag_nx;
    end
  end

  // Output holding register, handshake and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      real_out_q  <= '0;
      imag_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (w_load) begin
        real_out_q  <= w_real_nx;
        imag_out_q  <= w_imag_nx;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (w_complete && out_valid_q && !out_ready_i) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign real_out_o  = real_out_q;
  assign imag_out_o  = imag_out_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_serial_2_parallel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_2_parallel
//  Description : Self-checking bench for serial_2_parallel (N=32, W=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_2_parallel;

  localparam int N = 32;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable, frame_start, out_ready;
  logic [N-1:0]   real_in, imag_in;
  logic [N*W-1:0] real_out, imag_out;
  logic           out_valid, busy, overflow;

  serial_2_parallel #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .frame_start_i(frame_start),
    .real_in_i    (real_in),
    .imag_in_i    (imag_in),
    .real_out_o   (real_out),
    .imag_out_o   (imag_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] tx_r [N];
  logic [W-1:0] tx_i [N];
  bit           early_valid;
  bit           busy_gap;

  typedef struct {
    logic [W-1:0] rbase;
    logic [W-1:0] rstep;
    logic [W-1:0] ibase;
    logic [W-1:0] istep;
    bit           gaps;
    logic [W-1:0] exp_r0;    // hand-computed real lane 0
    logic [W-1:0] exp_i31;   // hand-computed imag lane 31
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_tx(input logic [W-1:0] rb, input logic [W-1:0] rs,
                        input logic [W-1:0] ib, input logic [W-1:0] is);
    for (int i = 0; i < N; i++) begin
      tx_r[i] = rb + W'(i) * rs;
      tx_i[i] = ib + W'(i) * is;
    end
  endtask

  function automatic logic [N*W-1:0] exp_flat(input bit imag);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = imag ? tx_i[i] : tx_r[i];
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive one enabled bit (bit index b of the tx words), then go idle with junk data.
  task automatic drive_bit(input int b, input bit fs);
    enable      = 1'b1;
    frame_start = fs;
    for (int i = 0; i < N; i++) begin
      real_in[i] = tx_r[i][b];
      imag_in[i] = tx_i[i][b];
    end
    @(posedge clk); #1;
    enable      = 1'b0;
    frame_start = 1'b0;
    real_in     = $urandom;
    imag_in     = $urandom;
  endtask

  task automatic send_frame(input bit gaps, input bit ready_last);
    early_valid = 1'b0;
    busy_gap    = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      if (gaps && b != W - 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          if (!busy) busy_gap = 1'b1;
          if (out_valid) early_valid = 1'b1;
        end
      end
      if (b == 0 && ready_last) out_ready = 1'b1;
      drive_bit(b, b == W - 1);
      if (b != 0) begin
        if (!busy) busy_gap = 1'b1;
        if (out_valid) early_valid = 1'b1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'h1000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 16'h1000, 16'hFFE0};
    vecs[1] = '{16'hA5C3, 16'h0000, 16'hA5C3, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3};
    vecs[2] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h8000, 16'h0111, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 16'h7FFF};
    vecs[4] = '{16'h1234, 16'h0000, 16'h5678, 16'h0000, 1'b1, 16'h1234, 16'h5678};

    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    real_in = '0; imag_in = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_valid",    out_valid, 0);
    chk("reset_busy",     busy,      0);
    chk("reset_overflow", overflow,  0);
    chk("reset_real",     real_out,  0);
    chk("reset_imag",     imag_out,  0);

    // Table-driven frames, consumer always ready.
    for (int v = 0; v < 5; v++) begin
      out_ready = 1'b1;
      idle(1);
      chk($sformatf("v%0d_drained", v), out_valid, 0);
      set_tx(vecs[v].rbase, vecs[v].rstep, vecs[v].ibase, vecs[v].istep);
      send_frame(vecs[v].gaps, 1'b0);
      chk($sformatf("v%0d_valid", v),       out_valid,   1);
      chk($sformatf("v%0d_no_early", v),    early_valid, 0);
      chk($sformatf("v%0d_busy_held", v),   busy_gap,    0);
      chk($sformatf("v%0d_busy_done", v),   busy,        0);
      chk($sformatf("v%0d_real", v),        real_out,    exp_flat(1'b0));
      chk($sformatf("v%0d_imag", v),        imag_out,    exp_flat(1'b1));
      chk($sformatf("v%0d_real_l0", v),     real_out[0*W +: W],  vecs[v].exp_r0);
      chk($sformatf("v%0d_imag_l31", v),    imag_out[31*W +: W], vecs[v].exp_i31);
      chk($sformatf("v%0d_overflow", v),    overflow,    0);
    end
    idle(1);
    chk("table_accept_clears", out_valid, 0);

    // Frame 2's last bit coincides with accept of frame 1.
    out_ready = 1'b0;
    set_tx(16'h1111, 16'h0000, 16'hEEEE, 16'h0000);
    send_frame(1'b0, 1'b0);
    chk("sim_first_valid", out_valid, 1);
    set_tx(16'h2222, 16'h0000, 16'hDDDD, 16'h0000);
    send_frame(1'b0, 1'b1);
    chk("sim_valid",    out_valid, 1);
    chk("sim_real",     real_out,  {N{16'h2222}});
    chk("sim_imag",     imag_out,  {N{16'hDDDD}});
    chk("sim_overflow", overflow,  0);
    out_ready = 1'b1;
    idle(1);

    // Resync: 7-bit partial frame, then a full frame restarts on frame_start.
    set_tx(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    for (int b = W - 1; b >= W - 7; b--) drive_bit(b, b == W - 1);
    chk("resync_busy_partial",  busy,      1);
    chk("resync_valid_partial", out_valid, 0);
    set_tx(16'h0F0F, 16'h0000, 16'hF0F0, 16'h0000);
    send_frame(1'b0, 1'b0);
    chk("resync_no_early", early_valid, 0);
    chk("resync_valid",    out_valid,   1);
    chk("resync_real",     real_out,    {N{16'h0F0F}});
    chk("resync_imag",     imag_out,    {N{16'hF0F0}});
    chk("resync_overflow", overflow,    0);
    idle(1);

    // Backpressure: second frame dropped while first is held.
    out_ready = 1'b0;
    set_tx(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
    send_frame(1'b0, 1'b0);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_ovf",   overflow,  0);
    set_tx(16'h8000, 16'h0000, 16'h8000, 16'h0000);
    send_frame(1'b0, 1'b0);
    chk("bp_valid_held", out_valid, 1);
    chk("bp_real_held",  real_out,  {N{16'h7FFF}});
    chk("bp_imag_held",  imag_out,  {N{16'h7FFF}});
    chk("bp_overflow",   overflow,  1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_drained",     out_valid, 0);
    chk("bp_ovf_sticky",  overflow,  1);
    chk("bp_data_kept",   real_out,  {N{16'h7FFF}});

    // Reset mid-frame (bit 9) with a word pending.
    set_tx(16'h3333, 16'h0000, 16'hCCCC, 16'h0000);
    send_frame(1'b0, 1'b0);
    chk("rst_pending_valid", out_valid, 1);
    set_tx(16'h4444, 16'h0000, 16'hBBBB, 16'h0000);
    for (int b = W - 1; b >= W - 9; b--) drive_bit(b, b == W - 1);
    chk("rst_busy_before", busy, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_valid",    out_valid, 0);
    chk("rst_busy",     busy,      0);
    chk("rst_overflow", overflow,  0);
    chk("rst_real",     real_out,  0);
    chk("rst_imag",     imag_out,  0);
    out_ready = 1'b1;
    set_tx(16'h5A5A, 16'h0001, 16'h8001, 16'h0000);
    send_frame(1'b1, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_real",  real_out,  exp_flat(1'b0));
    chk("post_rst_imag",  imag_out,  exp_flat(1'b1));
    chk("post_rst_l0",    real_out[0*W +: W], 16'h5A5A);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_2_parallel.md
# serial_2_parallel

Receive-side counterpart of the FFT32 output serializer. The block collects 2·N one-bit serial lanes, N real and N imaginary, and shifts W bits into each lane, MSB first. It then presents N signed W-bit complex samples in parallel under a valid/ready handshake. It sits at the FFT32 input boundary and rebuilds bit-serial sample frames into the parallel word set the butterfly stages consume.

## Interface
- N, default 32: number of complex lanes.
- W, default 16: bits per sample (signed two's complement).
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  bit strobe; lane inputs are sampled only on cycles with enable=1.
- frame_start  input  1  qualifies the current enabled bit as the MSB of a new frame; ignored when enable=0.
- real_in  input  1 × [0:N-1]  serial real lanes.
- imag_in  input  1 × [0:N-1]  serial imaginary lanes.
- real_out  output  signed W × [0:N-1]  parallel real samples.
- imag_out  output  signed W × [0:N-1]  parallel imaginary samples.
- out_valid  output  1  parallel word set is valid.
- out_ready  input  1  consumer accepts on out_valid && out_ready.
- busy  output  1  a frame is partially received.
- overflow  output  1  sticky: a completed frame was dropped.

## Operation
- Per lane: a W-bit shift register; on an accepted bit, sr <= {sr[W-2:0], bit_in}.
- bit_cnt, 0..W-1, is shared by all lanes. The FSM has two states: IDLE and SHIFT.
- IDLE:
  - enable && frame_start: capture the MSB, bit_cnt <= 1, go to SHIFT.
  - All other bits are discarded.
- SHIFT:
  - enable=1: capture a bit, bit_cnt++.
  - enable=0: hold everything; gaps of any length are allowed.
- Completion: the bit captured with bit_cnt = W-1 completes the frame.
  - The full shifted word is loaded into the output registers (when allowed, see below).
  - bit_cnt <= 0, FSM returns to IDLE.
- frame_start while in SHIFT: the partial frame is discarded silently. That bit becomes the MSB of the new frame, bit_cnt <= 1, and overflow is unaffected.
- Output holding register, with frame completion at an edge:
  - out_valid=0, or out_ready=1 at that edge: load the new word, out_valid <= 1.
  - out_valid=1 and out_ready=0: the new frame is dropped, outputs are unchanged, overflow <= 1.
- Handshake with no completion: out_valid && out_ready clears out_valid. Data registers keep their last value.
- Completion and accept in the same cycle: the new word is loaded and out_valid stays 1. This is not an overflow.
- overflow clears only on rst.
- busy = (state == SHIFT).
- No arithmetic. Output words are the raw received bits, interpreted as signed.
- With W=1, every enabled frame_start completes a frame immediately.

## Timing
- Reset values: real_out/imag_out all 0, out_valid 0, busy 0, overflow 0, state IDLE, bit_cnt 0.
- rst mid-frame aborts the frame. A pending out_valid is dropped.
- Latency: the W-th bit is sampled at edge k, and out_valid/data are visible after edge k.
- Minimum frame period is W enabled cycles, back to back. frame_start may coincide with the first bit after a completion.
- out_valid and data are stable while out_valid && !out_ready.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic: N=32, W=16; lane i real carries 16'h1000+i and imag carries -(i+1), MSB first, enable=1 and out_ready=1 throughout. Required: out_valid after the 16th edge, real_out[i]=16'h1000+i, imag_out[i]=-(i+1).
- Gapped enable: send 16'hA5C3 on all lanes with enable toggling 1-0-0-1… (random gaps). Required: the same word is received, out_valid asserts only after the 16th enabled bit, and busy=1 throughout the frame.
- Backpressure: out_ready=0. The first frame 16'h7FFF is held valid; the second frame 16'h8000 completes. Required: outputs remain 16'h7FFF and overflow=1. After out_ready=1 for one cycle, out_valid drops to 0.
- Simultaneous: frame 2's last bit lands on the same edge that accepts frame 1. Required: frame 2 data is loaded, out_valid stays 1, overflow=0.
- Resync: frame_start is reasserted after 7 bits, then a full frame of 16'h0F0F follows. Required: 16'h0F0F is output, no output is produced for the aborted partial, overflow=0.
- Reset: rst=1 at bit 9 of a frame and while out_valid=1. Required: the next cycle shows out_valid=0, busy=0, overflow=0, outputs=0, and a subsequent full frame is received correctly.
